// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use/branch-flush/memory-wait stall sequencer for a 5-stage RV32I pipeline
//   clk_i, rst_i            clock (rising edge), asynchronous active-high reset
//   RS1addr_i, RS2addr_i    source registers of the instruction in ID
//   UsesRS2_i               ID instruction reads rs2
//   EX_RDaddr_i             destination register of the instruction in EX
//   EX_MemRead_i            EX instruction is a load
//   BranchTaken_i           branch/jump resolved taken in EX
//   dmem_req_i              MEM stage performs a load/store
//   dmem_ready_i            data memory completes the access this cycle
//   hazard_o                control mux inserts a bubble into ID_EX
//   PCWrite_o, IF_IDwrite_o PC and IF_ID enables
//   IF_IDflush_o            squash the fetched instruction
//   ID_EXflush_o            squash the decoded instruction
//   freeze_o                hold ID_EX, EX_MEM, MEM_WB during a memory wait
//   stall_cnt_o             saturating count of cycles with PCWrite_o low
//   err_o                   sticky data-memory timeout flag
module hazard_ctrl #(
    parameter int FLUSH_LEN   = 1,
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       RS1addr_i,
    input  logic [4:0]       RS2addr_i,
    input  logic             UsesRS2_i,
    input  logic [4:0]       EX_RDaddr_i,
    input  logic             EX_MemRead_i,
    input  logic             BranchTaken_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    output logic             hazard_o,
    output logic             PCWrite_o,
    output logic             IF_IDwrite_o,
    output logic             IF_IDflush_o,
    output logic             ID_EXflush_o,
    output logic             freeze_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             err_o
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;
    localparam logic [15:0] TIMEOUT = 16'(MEM_TIMEOUT);
    localparam logic [3:0]  LAST    = 4'(FLUSH_LEN - 1);
    state_t      state, nextState;
    logic [3:0]  fcnt, nextFcnt;
    logic [15:0] wcnt, nextWcnt;
    logic        setErr, loadUse, memWait;
    always_comb begin
        loadUse = EX_MemRead_i && EX_RDaddr_i != 5'd0 &&
                  (EX_RDaddr_i == RS1addr_i || (UsesRS2_i && EX_RDaddr_i == RS2addr_i));
        memWait = dmem_req_i && !dmem_ready_i;
        nextState = state;
        nextFcnt = fcnt;
        nextWcnt = wcnt;
        setErr = 1'b0;
        hazard_o = 1'b0;
        PCWrite_o = 1'b1;
        IF_IDwrite_o = 1'b1;
        IF_IDflush_o = 1'b0;
        ID_EXflush_o = 1'b0;
        freeze_o = 1'b0;
        // Gating on rst_i makes the outputs take reset values combinationally while reset is held.
        if (!rst_i) begin
            if (state == MEM_WAIT || memWait) begin
                freeze_o = 1'b1;
                PCWrite_o = 1'b0;
                IF_IDwrite_o = 1'b0;
            end else if (state == FLUSH) begin
                IF_IDflush_o = 1'b1;
            end else if (BranchTaken_i) begin
                IF_IDflush_o = 1'b1;
                ID_EXflush_o = 1'b1;
            end else if (loadUse) begin
                hazard_o = 1'b1;
                PCWrite_o = 1'b0;
                IF_IDwrite_o = 1'b0;
            end
            if (state == MEM_WAIT) begin
                // wcnt saturates at the timeout so it cannot wrap during an endless wait.
                nextWcnt = wcnt == TIMEOUT ? wcnt : wcnt + 16'd1;
                setErr = !dmem_ready_i && nextWcnt == TIMEOUT;
                nextState = dmem_ready_i ? RUN : MEM_WAIT;
            end else if (memWait) begin
                nextState = MEM_WAIT;
                nextWcnt = 16'd1;
            end else if (state == FLUSH) begin
                nextState = fcnt == LAST ? RUN : FLUSH;
                nextFcnt = fcnt + 4'd1;
            end else if (BranchTaken_i && FLUSH_LEN > 1) begin
                nextState = FLUSH;
                nextFcnt = 4'd1;
            end
        end
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= RUN;
            fcnt <= '0;
            wcnt <= '0;
            err_o <= 1'b0;
            stall_cnt_o <= '0;
        end else begin
            state <= nextState;
            fcnt <= nextFcnt;
            wcnt <= nextWcnt;
            err_o <= err_o | setErr;
            stall_cnt_o <= (!PCWrite_o && !(&stall_cnt_o)) ? stall_cnt_o + 1'b1 : stall_cnt_o;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: randomized and directed checks of hazard_ctrl against a cycle-level reference model
module tb_hazard_ctrl;
    localparam int FL = 3;
    localparam int TO = 4;
    localparam int CW = 8;
    localparam int CMAX = (1 << CW) - 1;
    logic          clk_i = 1'b0, rst_i = 1'b0;
    logic [4:0]    RS1addr_i = '0, RS2addr_i = '0, EX_RDaddr_i = '0;
    logic          UsesRS2_i = 1'b0, EX_MemRead_i = 1'b0, BranchTaken_i = 1'b0;
    logic          dmem_req_i = 1'b0, dmem_ready_i = 1'b0;
    logic          hazard_o, PCWrite_o, IF_IDwrite_o, IF_IDflush_o, ID_EXflush_o, freeze_o, err_o;
    logic [CW-1:0] stall_cnt_o;
    int            checks = 0, passed = 0;
    bit            waiting = 0, mErr = 0;
    int            waitCycles = 0, flushLeft = 0, stalls = 0;
    hazard_ctrl #(.FLUSH_LEN(FL), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .RS1addr_i(RS1addr_i), .RS2addr_i(RS2addr_i),
        .UsesRS2_i(UsesRS2_i), .EX_RDaddr_i(EX_RDaddr_i), .EX_MemRead_i(EX_MemRead_i),
        .BranchTaken_i(BranchTaken_i), .dmem_req_i(dmem_req_i), .dmem_ready_i(dmem_ready_i),
        .hazard_o(hazard_o), .PCWrite_o(PCWrite_o), .IF_IDwrite_o(IF_IDwrite_o),
        .IF_IDflush_o(IF_IDflush_o), .ID_EXflush_o(ID_EXflush_o), .freeze_o(freeze_o),
        .stall_cnt_o(stall_cnt_o), .err_o(err_o)
    );
    always #5 clk_i = ~clk_i;
    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask
    task automatic idleInputs();
        {RS1addr_i, RS2addr_i, EX_RDaddr_i} = '0;
        {UsesRS2_i, EX_MemRead_i, BranchTaken_i, dmem_req_i, dmem_ready_i} = '0;
    endtask
    task automatic doReset();
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        checkVal("rst_hazard", hazard_o, 0);
        checkVal("rst_pcwrite", PCWrite_o, 1);
        checkVal("rst_ifidwrite", IF_IDwrite_o, 1);
        checkVal("rst_ifidflush", IF_IDflush_o, 0);
        checkVal("rst_idexflush", ID_EXflush_o, 0);
        checkVal("rst_freeze", freeze_o, 0);
        checkVal("rst_err", err_o, 0);
        checkVal("rst_cnt", stall_cnt_o, 0);
        waiting = 0; mErr = 0; waitCycles = 0; flushLeft = 0; stalls = 0;
        @(negedge clk_i);
        idleInputs();
        rst_i = 1'b0;
    endtask
    // One cycle: apply inputs, compare all outputs with the model, then advance the model at the edge.
    task automatic step(input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                        input logic [4:0] exRd, input logic exMr, input logic br,
                        input logic req, input logic rdy);
        bit mw, lu, eHaz, ePc, eIfw, eIff, eIdf, eFrz;
        @(negedge clk_i);
        RS1addr_i = rs1; RS2addr_i = rs2; UsesRS2_i = u2; EX_RDaddr_i = exRd;
        EX_MemRead_i = exMr; BranchTaken_i = br; dmem_req_i = req; dmem_ready_i = rdy;
        #1;
        mw = req && !rdy;
        lu = exMr && exRd != 0 && (exRd == rs1 || (u2 && exRd == rs2));
        eHaz = 0; ePc = 1; eIfw = 1; eIff = 0; eIdf = 0; eFrz = 0;
        if (waiting || mw) begin eFrz = 1; ePc = 0; eIfw = 0; end
        else if (flushLeft > 0) eIff = 1;
        else if (br) begin eIff = 1; eIdf = 1; end
        else if (lu) begin eHaz = 1; ePc = 0; eIfw = 0; end
        checkVal("hazard", hazard_o, eHaz);
        checkVal("pcwrite", PCWrite_o, ePc);
        checkVal("ifidwrite", IF_IDwrite_o, eIfw);
        checkVal("ifidflush", IF_IDflush_o, eIff);
        checkVal("idexflush", ID_EXflush_o, eIdf);
        checkVal("freeze", freeze_o, eFrz);
        checkVal("stall_cnt", stall_cnt_o, stalls);
        checkVal("err", err_o, mErr);
        @(posedge clk_i);
        if (!ePc && stalls < CMAX) stalls++;
        if (waiting) begin
            waitCycles++;
            if (rdy) waiting = 0;
            else if (waitCycles >= TO) mErr = 1;
        end else if (mw) begin
            waiting = 1; waitCycles = 1; flushLeft = 0;
        end else if (flushLeft > 0) flushLeft--;
        else if (br) flushLeft = FL - 1;
    endtask
    initial begin
        doReset();
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        doReset();
        step(5, 0, 0, 5, 1, 0, 0, 0);
        checkVal("t2_hazard_seen", hazard_o, 1);
        step(5, 0, 0, 5, 0, 0, 0, 0);
        checkVal("t2_cnt_one", stall_cnt_o, 1);
        step(0, 0, 1, 0, 1, 0, 0, 0);
        step(1, 7, 0, 7, 1, 0, 0, 0);
        step(1, 7, 1, 7, 1, 0, 0, 0);
        step(5, 0, 0, 5, 1, 1, 0, 0);
        step(5, 0, 0, 5, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        doReset();
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        checkVal("t5_cnt_four", stall_cnt_o, 4);
        step(0, 0, 0, 0, 0, 1, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 0, 1, 0);
        checkVal("t6_err_set", err_o, 1);
        step(0, 0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        checkVal("t6_err_sticky", err_o, 1);
        for (int i = 0; i < 600; i++) begin
            if (i % 150 == 0) doReset();
            step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom),
                 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom_range(0, 4) == 0),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0));
        end
        doReset();
        for (int i = 0; i < CMAX + 10; i++) step(0, 0, 0, 0, 0, 0, 1, 0);
        checkVal("cnt_saturated", stall_cnt_o, CMAX);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
